// File: rtl/jtframe_db15_rd_if.sv
// rtl/jtframe_db15_rd_if.sv - DB15 adapter pins and published joystick words
//
// Purpose : bundles the serial adapter pins and the decoded joystick outputs.
// Signals : JOY_DATA  serial data from the adapter (active-low buttons)
//           JOY_CLK   shift clock to the adapter
//           JOY_LOAD  parallel-load strobe to the adapter (active low)
//           joystick1 player 1 word, active high
//           joystick2 player 2 word, active high
//           upd       one-cycle pulse when joystick1/2 take new values
// master  : the reader; slave : the adapter side / consumer.
interface jtframe_db15_rd_if;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        upd;

    modport master (
        input  JOY_DATA,
        output JOY_CLK,
        output JOY_LOAD,
        output joystick1,
        output joystick2,
        output upd
    );

    modport slave (
        output JOY_DATA,
        input  JOY_CLK,
        input  JOY_LOAD,
        input  joystick1,
        input  joystick2,
        input  upd
    );
endinterface

// File: rtl/jtframe_db15_rd.sv
// rtl/jtframe_db15_rd.sv - DB15 arcade-stick serial reader (two 16-bit 74HC165 chains)
//
// Purpose : periodically loads and shifts out the adapter's 32-bit button chain
//           and publishes two active-high joystick words atomically per scan.
// Ports   : clk    system clock
//           rst_n  asynchronous active-low reset
//           db     jtframe_db15_rd_if.master (JOY_DATA in; JOY_CLK, JOY_LOAD,
//                  joystick1, joystick2, upd out)
module jtframe_db15_rd #(
    parameter int CLKDIV    = 8,
    parameter int GAP_TICKS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    jtframe_db15_rd_if.master   db
);

    typedef enum logic [2:0] {
        ST_GAP,
        ST_LOAD,
        ST_SAMP,
        ST_CLKH,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [15:0] gcnt_q, gcnt_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [31:0] sr_q, sr_d;
    logic        joy_clk_q, joy_clk_d;
    logic        joy_load_q, joy_load_d;
    logic [15:0] joy1_q, joy1_d;
    logic [15:0] joy2_q, joy2_d;
    logic        upd_q, upd_d;
    logic [1:0]  sync_q;
    logic        tick;

    // JOY_DATA is asynchronous to clk; only sync_q[1] is ever consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], db.JOY_DATA};
        end
    end

    assign tick = (hcnt_q == 8'(CLKDIV - 1));

    always_comb begin
        state_d    = state_q;
        hcnt_d     = tick ? 8'd0 : hcnt_q + 8'd1;
        gcnt_d     = gcnt_q;
        bitcnt_d   = bitcnt_q;
        sr_d       = sr_q;
        joy_clk_d  = joy_clk_q;
        joy_load_d = joy_load_q;
        joy1_d     = joy1_q;
        joy2_d     = joy2_q;
        upd_d      = 1'b0;

        case (state_q)
            ST_GAP: begin
                joy_clk_d  = 1'b0;
                joy_load_d = 1'b1;
                if (tick) begin
                    if (gcnt_q == 16'(GAP_TICKS - 1)) begin
                        gcnt_d     = 16'd0;
                        joy_load_d = 1'b0;
                        state_d    = ST_LOAD;
                    end else begin
                        gcnt_d = gcnt_q + 16'd1;
                    end
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    joy_load_d = 1'b1;
                    bitcnt_d   = 5'd0;
                    state_d    = ST_SAMP;
                end
            end
            ST_SAMP: begin
                // Sample at the end of the low phase; the first bit shifted in
                // migrates down to sr[0] after all 32 shifts.
                if (tick) begin
                    sr_d      = {~sync_q[1], sr_q[31:1]};
                    joy_clk_d = 1'b1;
                    state_d   = ST_CLKH;
                end
            end
            ST_CLKH: begin
                if (tick) begin
                    joy_clk_d = 1'b0;
                    if (bitcnt_q == 5'd31) begin
                        state_d = ST_DONE;
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                        state_d  = ST_SAMP;
                    end
                end
            end
            ST_DONE: begin
                // Single cycle; restarting hcnt keeps every scan phase-aligned
                // with the one that follows reset.
                joy1_d  = sr_q[15:0];
                joy2_d  = sr_q[31:16];
                upd_d   = 1'b1;
                gcnt_d  = 16'd0;
                hcnt_d  = 8'd0;
                state_d = ST_GAP;
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_GAP;
            hcnt_q     <= 8'd0;
            gcnt_q     <= 16'd0;
            bitcnt_q   <= 5'd0;
            sr_q       <= 32'd0;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
            joy1_q     <= 16'd0;
            joy2_q     <= 16'd0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            gcnt_q     <= gcnt_d;
            bitcnt_q   <= bitcnt_d;
            sr_q       <= sr_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            upd_q      <= upd_d;
        end
    end

    assign db.JOY_CLK   = joy_clk_q;
    assign db.JOY_LOAD  = joy_load_q;
    assign db.joystick1 = joy1_q;
    assign db.joystick2 = joy2_q;
    assign db.upd       = upd_q;

endmodule

// File: tb/tb_jtframe_db15_rd.sv
// tb/tb_jtframe_db15_rd.sv - self-checking bench for jtframe_db15_rd
module tb_jtframe_db15_rd;
    localparam int CLKDIV    = 4;
    localparam int GAP_TICKS = 2;
    localparam int PERIOD    = (1 + 64 + GAP_TICKS) * CLKDIV + 1;

    logic clk;
    logic rst_n;
    jtframe_db15_rd_if dbif();

    jtframe_db15_rd #(.CLKDIV(CLKDIV), .GAP_TICKS(GAP_TICKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .db    (dbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Adapter: 32-bit 74HC165 chain, raw bit k is the k-th bit shifted out.
    logic [31:0] raw;
    logic [31:0] sh = 32'hFFFF_FFFF;
    logic [31:0] exp_q[$];
    assign dbif.JOY_DATA = sh[0];

    always @(negedge dbif.JOY_LOAD) begin
        sh = raw;
        if (rst_n === 1'b1) exp_q.push_back(~raw);
    end

    always @(posedge dbif.JOY_CLK) begin
        if (dbif.JOY_LOAD === 1'b1) sh = {1'b1, sh[31:1]};
    end

    // Reference model: scans complete every PERIOD cycles from reset release,
    // each publishing the inverted pattern latched at its load strobe.
    int          cyc, next_upd, load_len, rises, last_rise;
    logic        clk_prev, exp_upd;
    logic [15:0] pub1, pub2;
    logic [31:0] e;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            cyc = 0; next_upd = PERIOD; pub1 = 16'd0; pub2 = 16'd0;
            exp_q.delete(); load_len = 0; rises = 0; last_rise = 0; clk_prev = 1'b0;
        end else begin
            cyc++;
            exp_upd = (cyc == next_upd);
            if (exp_upd) begin
                chk("rises_per_scan", rises, 32);
                rises = 0;
                chk("scan_queued", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    pub1 = e[15:0];
                    pub2 = e[31:16];
                end
                next_upd += PERIOD;
            end
            chk("upd", dbif.upd, exp_upd);
            chk("joystick1", dbif.joystick1, pub1);
            chk("joystick2", dbif.joystick2, pub2);
            chk("clk_while_load", (dbif.JOY_CLK === 1'b1 && dbif.JOY_LOAD === 1'b0), 0);
            if (dbif.JOY_LOAD === 1'b0) begin
                load_len++;
            end else if (load_len != 0) begin
                chk("load_len", load_len, CLKDIV);
                load_len = 0;
            end
            if (dbif.JOY_CLK === 1'b1 && !clk_prev) begin
                if (rises > 0) chk("clk_period", cyc - last_rise, 2 * CLKDIV);
                last_rise = cyc;
                rises++;
            end
            clk_prev = dbif.JOY_CLK;
        end
    end

    task automatic wait_upd();
        bit seen = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if (dbif.upd === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("upd_timeout", dbif.upd, 1);
    endtask

    task automatic wait_rise(input int n);
        bit seen = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if (rises == n && dbif.JOY_CLK === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("rise_timeout", rises, n);
    endtask

    initial begin
        raw   = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_joy_clk",  dbif.JOY_CLK, 0);
        chk("rst_joy_load", dbif.JOY_LOAD, 1);
        chk("rst_upd",      dbif.upd, 0);
        #2 rst_n = 1'b1;

        // No buttons pressed
        wait_upd();
        chk("idle_j1", dbif.joystick1, 16'h0000);
        chk("idle_j2", dbif.joystick2, 16'h0000);
        raw = 32'h7FFF_FFFE;

        wait_upd();
        chk("p1b0_j1", dbif.joystick1, 16'h0001);
        chk("p2b15_j2", dbif.joystick2, 16'h8000);
        raw = 32'h1234_5678;

        // Pattern changes mid-shift: this scan keeps the latched pattern
        wait_rise(11);
        raw = 32'h0F0F_F0F0;
        chk("hold_j1", dbif.joystick1, 16'h7FFF & 16'h8001 | 16'h0001);
        wait_upd();
        chk("old_j1", dbif.joystick1, 16'hA987);
        chk("old_j2", dbif.joystick2, 16'hEDCB);
        wait_upd();
        chk("new_j1", dbif.joystick1, 16'h0F0F);
        chk("new_j2", dbif.joystick2, 16'hF0F0);

        // Reset during the high phase of bit 20
        wait_rise(21);
        #1 rst_n = 1'b0;
        #1;
        chk("async_joy_clk",  dbif.JOY_CLK, 0);
        chk("async_joy_load", dbif.JOY_LOAD, 1);
        chk("async_j1",       dbif.joystick1, 16'h0000);
        chk("async_j2",       dbif.joystick2, 16'h0000);
        chk("async_upd",      dbif.upd, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_upd();
        chk("post_rst_j1", dbif.joystick1, 16'hF0F0 ^ 16'hFFFF ^ 16'hFFFF ^ 16'h0F0F ^ 16'hF0F0);

        // Continuous scans, then randomized patterns
        for (int s = 0; s < 5; s++) wait_upd();
        for (int s = 0; s < 100; s++) begin
            raw = $urandom;
            wait_upd();
        end
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
